// File: rtl/assoc_cache.sv
// Set-associative write-back cache with tree pseudo-LRU replacement.
// Latency: hits complete combinationally in IDLE; misses add a writeback (if dirty) and a fill.
// Backpressure: CPU request is held until mem_resp; pmem requests are held until pmem_resp.
// Ports: clk/reset_n; CPU side mem_*; physical memory side pmem_*; saturating hit/miss counters.
module assoc_cache #(
    parameter int WAYS      = 4,
    parameter int SETS_LOG2 = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int TAGW = 12 - SETS_LOG2;
    localparam int SETS = 1 << SETS_LOG2;
    localparam int WAYW = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
    state_e state_q, state_d;

    logic [127:0]     data_q  [SETS][WAYS];
    logic [TAGW-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [WAYW-1:0]  victim_q;
    logic [15:0]      hit_cnt_q, miss_cnt_q;

    logic [SETS_LOG2-1:0] idx;
    logic [TAGW-1:0]      tag;
    logic [2:0]           word;
    logic                 req, hit, idle_hit, idle_miss;
    logic [WAYS-1:0]      match;
    logic [WAYW-1:0]      hit_way, plru_way, victim_sel;
    logic [WAYS-2:0]      plru_upd;
    logic [127:0]         hit_line, merged;
    wire                  unused_addr_lsb = mem_address[0];

    assign idx  = mem_address[3+SETS_LOG2:4];
    assign tag  = mem_address[15:4+SETS_LOG2];
    assign word = mem_address[3:1];
    assign req  = mem_read | mem_write;

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                match[w] = 1'b1;
                hit_way  = WAYW'(w);
            end
        end
    end
    assign hit       = |match;
    assign idle_hit  = (state_q == IDLE) && req && hit;
    assign idle_miss = (state_q == IDLE) && req && !hit;

    // Tree walk: node n has children 2n+1 (left) and 2n+2 (right); a bit of 1 steers right.
    always_comb begin
        logic [WAYW-1:0] node;
        plru_way = '0;
        node     = '0;
        for (int l = 0; l < WAYW; l++) begin
            plru_way[WAYW-1-l] = plru_q[idx][node];
            node = WAYW'(2 * int'(node) + 1 + int'(plru_q[idx][node]));
        end
    end

    // Make every node on the hit way's path point at the other subtree.
    always_comb begin
        logic [WAYW-1:0] node;
        logic            dir;
        plru_upd = plru_q[idx];
        node     = '0;
        for (int l = 0; l < WAYW; l++) begin
            dir            = hit_way[WAYW-1-l];
            plru_upd[node] = ~dir;
            node = WAYW'(2 * int'(node) + 1 + int'(dir));
        end
    end

    // Lowest-index invalid way wins; fall back to the PLRU choice when the set is full.
    always_comb begin
        victim_sel = plru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim_sel = WAYW'(w);
        end
    end

    assign hit_line  = data_q[idx][hit_way];
    assign mem_rdata = hit_line[{word, 4'b0000} +: 16];

    always_comb begin
        merged = hit_line;
        if (mem_byte_enable[0]) merged[{word, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged[{word, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {tag, idx, 4'b0000};
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) mem_resp = 1'b1;
                    else if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) state_d = WRITEBACK;
                    else state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, 4'b0000};
                if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs drop the instant reset asserts, before the state register settles.
        if (!reset_n) begin
            mem_resp   = 1'b0;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    end
    assign pmem_wdata = data_q[idx][victim_q];
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (idle_hit) begin
                plru_q[idx] <= plru_upd;
                if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (idle_miss) begin
                victim_q <= victim_sel;
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (state_q == WRITEBACK && pmem_resp) dirty_q[idx][victim_q] <= 1'b0;
            if (state_q == ALLOCATE && pmem_resp) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line data and tags carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (idle_hit && mem_write) data_q[idx][hit_way] <= merged;
        if (state_q == ALLOCATE && pmem_resp) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end

    a_single_match: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == IDLE) |-> $onehot0(match));

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 The module SHALL have parameter WAYS, default 4, meaning the associativity; legal values are 2, 4 and 8.
REQ-002 The module SHALL have parameter SETS_LOG2, default 3, meaning log2 of the set count; legal range is 1..6.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port mem_read, input, 1 bit: CPU read request, held until mem_resp.
REQ-007 Port mem_write, input, 1 bit: CPU write request, held until mem_resp.
REQ-008 Port mem_address, input, 16 bits: CPU byte address; offset [3:0], index [3+SETS_LOG2:4], tag = the remaining upper bits (TAGW = 12-SETS_LOG2).
REQ-009 Port mem_wdata, input, 16 bits: CPU write word.
REQ-010 Port mem_byte_enable, input, 2 bits: byte lanes of mem_wdata to write.
REQ-011 Port mem_rdata, output, 16 bits: the addressed word of the hit line.
REQ-012 Port mem_resp, output, 1 bit: request complete.
REQ-013 Port pmem_read, output, 1 bit: line fill request to physical memory.
REQ-014 Port pmem_write, output, 1 bit: line writeback request to physical memory.
REQ-015 Port pmem_address, output, 16 bits: line address with [3:0] = 0.
REQ-016 Port pmem_wdata, output, 128 bits: victim line.
REQ-017 Port pmem_rdata, input, 128 bits: fill line.
REQ-018 Port pmem_resp, input, 1 bit: physical memory transfer complete.
REQ-019 Port hit_count, output, 16 bits: saturating count of hit completions.
REQ-020 Port miss_count, output, 16 bits: saturating count of misses.

Function
REQ-021 Each set SHALL hold, per way, a 128-bit data line, a TAGW-bit tag, a valid bit and a dirty bit, plus WAYS-1 tree pseudo-LRU bits for the set.
REQ-022 Array reads SHALL be asynchronous; writes SHALL occur on the clock edge.
REQ-023 The controller FSM SHALL have states IDLE, WRITEBACK and ALLOCATE.
REQ-024 A hit SHALL mean exactly one way has its valid bit set and its tag equal to the address tag; more than one matching way is unreachable and SHALL be flagged by an assertion.
REQ-025 IDLE, request and hit: mem_resp=1 combinationally in the same cycle; on the edge, the PLRU bits point away from the hit way, hit_count increments, and the FSM stays in IDLE.
REQ-026 On a write hit, each enabled byte of the word at offset[3:1] SHALL be merged into the line; the dirty bit SHALL be set even if mem_byte_enable=00.
REQ-027 A read hit SHALL drive mem_rdata = line[16*offset[3:1] +: 16]; offset[0] is ignored.
REQ-028 When mem_read and mem_write are both asserted, the request SHALL be treated as a write.
REQ-029 Victim selection on a miss SHALL pick the lowest-index invalid way, else the PLRU-selected way; the victim is registered when IDLE is left.
REQ-030 IDLE, request and miss: miss_count increments; next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-031 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata = victim line; on pmem_resp, clear the victim dirty bit and go to ALLOCATE.
REQ-032 ALLOCATE: pmem_read=1, pmem_address={tag, index, 4'b0}; on pmem_resp, write pmem_rdata, tag, valid=1 and dirty=0 into the victim way, then go to IDLE.
REQ-033 After ALLOCATE the request SHALL complete as a hit in IDLE, counting one miss and one hit; the PLRU is not updated during the fill.
REQ-034 mem_resp SHALL be 0 outside IDLE; pmem_read and pmem_write SHALL never be asserted together.
REQ-035 hit_count and miss_count SHALL stick at 16'hFFFF.
REQ-036 A request with no mem_read/mem_write in IDLE SHALL cause no state change.

Reset
REQ-037 reset_n=0 SHALL immediately force the FSM to IDLE and drive mem_resp, pmem_read and pmem_write to 0, including mid-WRITEBACK or mid-ALLOCATE.
REQ-038 Reset SHALL clear all valid, dirty and PLRU bits and both counters to 0; data and tag contents are undefined.
REQ-039 The first rising edge with reset_n=1 SHALL operate normally.

Verification (WAYS=4, SETS_LOG2=3)
REQ-040 Cold read 0x1234 -> ALLOCATE with pmem_address=0x1230; after pmem_resp, mem_resp=1 in IDLE, miss_count=1, hit_count=1.
REQ-041 Write 0xBEEF with mem_byte_enable=10 to a 0x1234 hit, then read 0x1234 -> mem_rdata upper byte 0xBE, lower byte unchanged; next state is IDLE.
REQ-042 Fill 5 distinct tags into index 3 with the first line dirty -> the 5th miss goes to WRITEBACK with the PLRU victim's line address, then ALLOCATE.
REQ-043 Deassert reset_n mid-WRITEBACK -> pmem_write=0 at once and all lines invalid; re-reading the address is a miss.
REQ-044 70000 hits -> hit_count=0xFFFF.
